// File: rtl/memoria_datos_byte_write.sv
// MEM-stage data memory: byte-lane stores, extended loads,
// and a read-only second port that streams the whole array.
module memoria_datos_byte_write #(
   parameter int RAM_WIDTH                       = 32,
   parameter int RAM_DEPTH                       = 1024,
   parameter int CANT_COLUMNAS_MEM_DATOS         = 4,
   parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
   parameter int ADDR_W                          = $clog2(RAM_DEPTH) + 2
) (
   input  logic                                       i_clock,
   input  logic                                       i_reset,
   input  logic                                       i_enable,
   input  logic [CANT_COLUMNAS_MEM_DATOS-1:0]         i_write_read_mem,
   input  logic                                       i_read_mem,
   input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos,
   input  logic [ADDR_W-1:0]                          i_address,
   input  logic [RAM_WIDTH-1:0]                       i_data_write,
   output logic [RAM_WIDTH-1:0]                       o_data_read,
   output logic                                       o_valid_read,
   input  logic                                       i_debug_dump,
   output logic [RAM_WIDTH-1:0]                       o_debug_data,
   output logic                                       o_debug_valid,
   output logic                                       o_debug_last
);

   localparam int CNT_W = ADDR_W - 2;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RAM_DEPTH - 1);

   localparam logic [1:0] SZ_BYTE = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [1:0] SZ_WORD = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DUMP,
      ST_FLUSH
   } state_t;

   logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];

   logic [CNT_W-1:0]             word_idx;
   logic [1:0]                   size;
   logic                         store_en;
   logic                         load_en;
   logic [CANT_COLUMNAS_MEM_DATOS-1:0] lane_we;
   logic [RAM_WIDTH-1:0]         wdata;

   logic [RAM_WIDTH-1:0]         rd_word;
   logic [1:0]                   off_q;
   logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] sel_q;
   logic [RAM_WIDTH-1:0]         shift_b;
   logic [RAM_WIDTH-1:0]         shift_h;
   logic [7:0]                   field_b;
   logic [15:0]                  field_h;

   state_t                       state;
   state_t                       state_nxt;
   logic [CNT_W-1:0]             cnt;
   logic                         cnt_clr;
   logic                         rd_b;

   assign word_idx = i_address[ADDR_W-1:2];
   assign size     = i_select_bytes_mem_datos[1:0];
   // A load blocks every lane write, whatever the upstream enables say.
   assign store_en = i_enable & ~i_read_mem;
   assign load_en  = i_enable & i_read_mem;
   assign lane_we  = store_en ? i_write_read_mem : '0;

   // Replicate the store value across lanes so the enables pick the target.
   always_comb begin
      wdata = i_data_write;
      case (size)
         SZ_BYTE: wdata = {CANT_COLUMNAS_MEM_DATOS{i_data_write[7:0]}};
         SZ_HALF: wdata = {(CANT_COLUMNAS_MEM_DATOS/2){i_data_write[15:0]}};
         default: wdata = i_data_write;
      endcase
   end

   // Port A: per-lane write and synchronous word read; no reset on the array.
   always_ff @(posedge i_clock) begin
      for (int k = 0; k < CANT_COLUMNAS_MEM_DATOS; k++) begin
         if (lane_we[k]) begin
            ram[word_idx][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
      if (load_en) begin
         rd_word <= ram[word_idx];
      end
   end

   // Load side-band: offset/select travel with the read word; valid tracks loads.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         off_q        <= '0;
         sel_q        <= '0;
         o_valid_read <= 1'b0;
      end else if (i_enable) begin
         o_valid_read <= i_read_mem;
         if (i_read_mem) begin
            off_q <= i_address[1:0];
            sel_q <= i_select_bytes_mem_datos;
         end
      end
   end

   assign shift_b = rd_word >> {off_q, 3'b000};
   assign shift_h = rd_word >> {off_q[1], 4'b0000};
   assign field_b = shift_b[7:0];
   assign field_h = shift_h[15:0];

   // Field extraction and extension; a size of 0 yields zero.
   always_comb begin
      o_data_read = '0;
      case (sel_q[1:0])
         SZ_BYTE: begin
            if (sel_q[2]) o_data_read = {{(RAM_WIDTH-8){1'b0}}, field_b};
            else          o_data_read = {{(RAM_WIDTH-8){field_b[7]}}, field_b};
         end
         SZ_HALF: begin
            if (sel_q[2]) o_data_read = {{(RAM_WIDTH-16){1'b0}}, field_h};
            else          o_data_read = {{(RAM_WIDTH-16){field_h[15]}}, field_h};
         end
         SZ_WORD: o_data_read = rd_word;
         default: o_data_read = '0;
      endcase
   end

   // Dump FSM state register.
   always_ff @(posedge i_clock) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Dump FSM next state and port-B read strobe.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      rd_b      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_debug_dump) begin
               cnt_clr   = 1'b1;
               state_nxt = ST_DUMP;
            end
         end
         ST_DUMP: begin
            rd_b = 1'b1;
            if (cnt == LAST_IDX) state_nxt = ST_FLUSH;
         end
         ST_FLUSH: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Dump word counter; it stops at the last index instead of wrapping.
   always_ff @(posedge i_clock) begin
      if (i_reset)                          cnt <= '0;
      else if (cnt_clr)                     cnt <= '0;
      else if (rd_b && (cnt != LAST_IDX))   cnt <= cnt + 1'b1;
   end

   // Port B: registered read of the dumped word plus valid/last flags.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_debug_data  <= '0;
         o_debug_valid <= 1'b0;
         o_debug_last  <= 1'b0;
      end else begin
         o_debug_valid <= rd_b;
         o_debug_last  <= rd_b && (cnt == LAST_IDX);
         if (rd_b) o_debug_data <= ram[cnt];
      end
   end

endmodule

// File: tb/tb_memoria_datos_byte_write.sv
// Directed bench: stores, extended loads, priority/freeze rules,
// debug dump on a small instance, and reset during a dump.
module tb_memoria_datos_byte_write;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  we;
   logic        rd;
   logic [2:0]  sel;
   logic [11:0] addr;
   logic [31:0] wd;
   logic        dump;

   logic [31:0] a_data, a_ddata;
   logic        a_valid, a_dvalid, a_dlast;
   logic [31:0] b_data, b_ddata;
   logic        b_valid, b_dvalid, b_dlast;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memoria_datos_byte_write u_dut (
      .i_clock                  (clk),
      .i_reset                  (rst),
      .i_enable                 (en),
      .i_write_read_mem         (we),
      .i_read_mem               (rd),
      .i_select_bytes_mem_datos (sel),
      .i_address                (addr),
      .i_data_write             (wd),
      .o_data_read              (a_data),
      .o_valid_read             (a_valid),
      .i_debug_dump             (1'b0),
      .o_debug_data             (a_ddata),
      .o_debug_valid            (a_dvalid),
      .o_debug_last             (a_dlast)
   );

   memoria_datos_byte_write #(.RAM_DEPTH(8), .ADDR_W(5)) u_small (
      .i_clock                  (clk),
      .i_reset                  (rst),
      .i_enable                 (en),
      .i_write_read_mem         (we),
      .i_read_mem               (rd),
      .i_select_bytes_mem_datos (sel),
      .i_address                (addr[4:0]),
      .i_data_write             (wd),
      .o_data_read              (b_data),
      .o_valid_read             (b_valid),
      .i_debug_dump             (dump),
      .o_debug_data             (b_ddata),
      .o_debug_valid            (b_dvalid),
      .o_debug_last             (b_dlast)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic [3:0] w, input logic r,
                        input logic [2:0] s, input logic [11:0] a,
                        input logic [31:0] d);
      en = e; we = w; rd = r; sel = s; addr = a; wd = d;
   endtask

   task automatic store(input logic [3:0] w, input logic [2:0] s,
                        input logic [11:0] a, input logic [31:0] d);
      drive(1'b1, w, 1'b0, s, a, d);
      tick();
      drive(1'b1, 4'h0, 1'b0, 3'd3, 12'h0, 32'h0);
   endtask

   task automatic load(input logic [2:0] s, input logic [11:0] a);
      drive(1'b1, 4'h0, 1'b1, s, a, 32'h0);
      tick();
      drive(1'b1, 4'h0, 1'b0, 3'd3, 12'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dump = 1'b0;
      drive(1'b1, 4'h0, 1'b0, 3'd3, 12'h0, 32'h0);
      tick();
      tick();
      checks++;
      if (a_data !== 32'h0 || a_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_port_a data=%h valid=%b exp 0/0", a_data, a_valid);
      end
      checks++;
      if (b_ddata !== 32'h0 || b_dvalid !== 1'b0 || b_dlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_debug data=%h valid=%b last=%b exp 0", b_ddata, b_dvalid, b_dlast);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word();
      store(4'hF, 3'd3, 12'h010, 32'hDEADBEEF);
      load(3'd3, 12'h010);
      checks++;
      if (a_data !== 32'hDEADBEEF || a_valid !== 1'b1) begin
         errors++;
         $display("FAIL lw_0x10 data=%h valid=%b exp deadbeef/1", a_data, a_valid);
      end
      tick();
      checks++;
      if (a_valid !== 1'b0) begin
         errors++;
         $display("FAIL valid_drop valid=%b exp 0", a_valid);
      end
   endtask

   task automatic test_byte();
      store(4'hF, 3'd3, 12'h010, 32'h0);
      store(4'b0100, 3'd1, 12'h012, 32'h000000A5);
      load(3'd3, 12'h010);
      checks++;
      if (a_data !== 32'h00A50000) begin
         errors++;
         $display("FAIL sb_word data=%h exp 00a50000", a_data);
      end
      load(3'd1, 12'h012);
      checks++;
      if (a_data !== 32'hFFFFFFA5) begin
         errors++;
         $display("FAIL lb_0x12 data=%h exp ffffffa5", a_data);
      end
      load(3'd5, 12'h012);
      checks++;
      if (a_data !== 32'h000000A5) begin
         errors++;
         $display("FAIL lbu_0x12 data=%h exp 000000a5", a_data);
      end
   endtask

   task automatic test_half();
      store(4'hF, 3'd3, 12'h020, 32'h11227F33);
      store(4'b1100, 3'd2, 12'h022, 32'h00008001);
      load(3'd3, 12'h020);
      checks++;
      if (a_data !== 32'h80017F33) begin
         errors++;
         $display("FAIL sh_word data=%h exp 80017f33", a_data);
      end
      load(3'd2, 12'h022);
      checks++;
      if (a_data !== 32'hFFFF8001) begin
         errors++;
         $display("FAIL lh_0x22 data=%h exp ffff8001", a_data);
      end
      load(3'd6, 12'h022);
      checks++;
      if (a_data !== 32'h00008001) begin
         errors++;
         $display("FAIL lhu_0x22 data=%h exp 00008001", a_data);
      end
      load(3'd2, 12'h020);
      checks++;
      if (a_data !== 32'h00007F33) begin
         errors++;
         $display("FAIL lh_0x20 data=%h exp 00007f33", a_data);
      end
      load(3'd1, 12'h023);
      checks++;
      if (a_data !== 32'hFFFFFF80) begin
         errors++;
         $display("FAIL lb_0x23 data=%h exp ffffff80", a_data);
      end
      load(3'd5, 12'h021);
      checks++;
      if (a_data !== 32'h0000007F) begin
         errors++;
         $display("FAIL lbu_0x21 data=%h exp 0000007f", a_data);
      end
   endtask

   task automatic test_priority_freeze();
      drive(1'b1, 4'hF, 1'b1, 3'd3, 12'h020, 32'h12345678);
      tick();
      checks++;
      if (a_data !== 32'h80017F33 || a_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_priority data=%h valid=%b exp 80017f33/1", a_data, a_valid);
      end
      drive(1'b0, 4'hF, 1'b0, 3'd3, 12'h020, 32'h12345678);
      tick();
      checks++;
      if (a_data !== 32'h80017F33 || a_valid !== 1'b1) begin
         errors++;
         $display("FAIL freeze_hold data=%h valid=%b exp 80017f33/1", a_data, a_valid);
      end
      load(3'd3, 12'h020);
      checks++;
      if (a_data !== 32'h80017F33) begin
         errors++;
         $display("FAIL no_write data=%h exp 80017f33", a_data);
      end
      load(3'd0, 12'h020);
      checks++;
      if (a_data !== 32'h0 || a_valid !== 1'b1) begin
         errors++;
         $display("FAIL size0 data=%h valid=%b exp 0/1", a_data, a_valid);
      end
      tick();
   endtask

   task automatic test_dump();
      int n;
      int first;
      int lastc;
      n = 0;
      first = 0;
      lastc = 0;
      for (int i = 0; i < 8; i++) begin
         store(4'hF, 3'd3, 12'(i * 4), 32'(i));
      end
      dump = 1'b1;
      tick();
      dump = 1'b0;
      for (int c = 0; c < 30; c++) begin
         tick();
         dump = (c == 3);
         if (b_dvalid) begin
            if (n == 0) first = c;
            lastc = c;
            checks++;
            if (b_ddata !== 32'(n)) begin
               errors++;
               $display("FAIL dump_data idx=%0d data=%h exp %h", n, b_ddata, 32'(n));
            end
            checks++;
            if (b_dlast !== (n == 7)) begin
               errors++;
               $display("FAIL dump_last idx=%0d last=%b exp %b", n, b_dlast, (n == 7));
            end
            n++;
         end
      end
      dump = 1'b0;
      checks++;
      if (n != 8) begin
         errors++;
         $display("FAIL dump_count words=%0d exp 8", n);
      end
      checks++;
      if (lastc - first != 7) begin
         errors++;
         $display("FAIL dump_span span=%0d exp 7", lastc - first);
      end
   endtask

   task automatic test_reset_mid_dump();
      bit found;
      bit stray;
      found = 1'b0;
      stray = 1'b0;
      dump = 1'b1;
      tick();
      dump = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (b_dvalid && b_ddata == 32'd2) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL dump_third_word seen=%b exp 1", found);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (b_ddata !== 32'h0 || b_dvalid !== 1'b0 || b_dlast !== 1'b0) begin
         errors++;
         $display("FAIL rst_dump_out data=%h valid=%b last=%b exp 0", b_ddata, b_dvalid, b_dlast);
      end
      checks++;
      if (a_data !== 32'h0 || a_valid !== 1'b0 || b_data !== 32'h0 || b_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_load_out a=%h/%b b=%h/%b exp 0", a_data, a_valid, b_data, b_valid);
      end
      for (int c = 0; c < 12; c++) begin
         tick();
         if (b_dvalid) stray = 1'b1;
      end
      checks++;
      if (stray) begin
         errors++;
         $display("FAIL rst_idle dump_valid_seen=%b exp 0", stray);
      end
      load(3'd3, 12'h00C);
      checks++;
      if (b_data !== 32'd3 || b_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_ram_small data=%h valid=%b exp 3/1", b_data, b_valid);
      end
      checks++;
      if (a_data !== 32'd3) begin
         errors++;
         $display("FAIL rst_ram_main data=%h exp 3", a_data);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_priority_freeze();
      test_dump();
      test_reset_mid_dump();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
